rv_fetch_unit: RTL
==================

// Module: rv_fetch_unit
// PURPOSE
//  Instruction fetch stage in front of the rv32 core's decode/execute logic; sole master of ibus.
//  Owns the fetch PC and issues one-word READs, one transaction outstanding at a time.
//  Buffers {pc, instruction, error} in a small FIFO and hands entries downstream over valid/ready.
//  Accepts a redirect (branch/JAL/JALR target) that flushes buffered and in-flight fetches.
// PARAMETERS
//  INITIAL_PC  32'h0000_0000  fetch address after reset
//  DEPTH       2              instruction buffer entries, >= 1
// PORTS
//  clk             in   1    clock
//  rst_n           in   1    synchronous active-low reset
//  ibus            master_bus_if.master  -  uses breq/bgnt/bstart/bdone/berror/ttype/tsize/addr/rdata
//  redirect_valid  in   1    load redirect_pc as new fetch PC; flush
//  redirect_pc     in   32   new fetch target
//  inst_valid      out  1    head entry available
//  inst_ready      in   1    consumer takes head entry this cycle
//  inst_data       out  32   instruction word (32'h0 when inst_error)
//  inst_pc         out  32   address the word was fetched from
//  inst_error      out  1    fetch faulted: bus error, or misaligned redirect_pc
// BEHAVIOUR
//  - Clock is clk; reset is synchronous, active-low on rst_n; all state is sampled on posedge clk.
//  - Reset: state=IDLE, fetch_pc=INITIAL_PC, FIFO empty, inst_valid=0, breq=0, bstart=0,
//    ttype=READ, tsize=WORD, addr=INITIAL_PC.
//    Reset asserted mid-transaction abandons it; a later bdone is ignored.
//  - ttype=READ and tsize=WORD are constant; ibus.wdata is driven 0; addr=fetch_pc in every state.
//  - FSM:
//    IDLE->REQ when count < DEPTH and no halt.
//    REQ: breq=1, bstart=1; on bgnt -> WAIT, fetch_pc += 4 (wraps mod 2^32).
//    WAIT: breq=1, bstart=0; on bdone push {req_pc, rdata, berror} -> IDLE, or -> HALT if berror.
//    HALT: no requests; left only by redirect.
//    DRAIN: breq=1, bstart=0; wait for bdone, discard the response -> IDLE.
//  - Issue gate: a request is issued only if count < DEPTH at the REQ entry, so a push never overflows.
//  - Best-case throughput: one instruction per 3 cycles (IDLE->REQ->WAIT) with bgnt and bdone same-cycle.
//  - Redirect (highest priority, except reset):
//    Flushes the FIFO the same edge; fetch_pc <= redirect_pc.
//    From WAIT or REQ-with-bgnt -> DRAIN; otherwise -> IDLE.
//    Redirect coincident with bdone: the response is discarded, -> IDLE.
//  - Misaligned redirect (redirect_pc[1:0] != 0): no bus access.
//    Push one entry {redirect_pc, 0, error=1} and go to HALT.
//  - FIFO rules:
//    Pop when inst_valid & inst_ready.
//    Push and pop in the same cycle are both honoured; count is unchanged.
//    Outputs come from the head entry, registered (no combinational path from ibus.rdata).
//    Empty: inst_valid=0 and inst_data/pc/error hold their last value.
//    Pointers wrap modulo DEPTH.
//  - Latencies:
//    Bus-grant to first addr: 1 cycle after reset release (IDLE->REQ).
//    bdone to inst_valid: next cycle.
//  - Assertion: bdone is never seen in IDLE/REQ/HALT (protocol violation).
// STRUCTURE
//  - rv_pkg holds fetch_state_e {IDLE, REQ, WAIT, DRAIN, HALT} and fetch_entry_t {pc, data, error}.
//    ttype_e/tsize_e stay where the bus interface defines them.
//  - Sub-module rv_fetch_fifo #(DEPTH, type T=fetch_entry_t):
//    sync FIFO with push, pop, flush, full, empty and count.
//  - Top level holds the FSM, fetch_pc, and the ibus drive.
// TESTING
//  1. Reset release with bgnt=1, bdone one cycle after grant
//     -> first addr=INITIAL_PC, then 0x4, 0x8.
//     Entries appear in order with matching inst_pc/inst_data.
//  2. inst_ready=0, DEPTH=2, two words fetched -> breq stays 0 and fetch_pc=INITIAL_PC+8.
//     Raise inst_ready for 1 cycle -> exactly one new request issued.
//  3. Redirect to 0x100 while in WAIT; bdone returns 0xDEAD_BEEF next cycle
//     -> word dropped, FIFO empty, next addr=0x100, first inst_pc=0x100.
//  4. berror on the fetch of 0x8 -> entry {pc=0x8, data=0, error=1} delivered.
//     breq stays 0 until redirect to 0x40 -> fetch resumes at 0x40.
//  5. Redirect to 0x102 -> no bus access; one entry {pc=0x102, error=1}; HALT.
//  6. rst_n low for 1 cycle during WAIT; stray bdone follows -> no entry pushed.
//     Fetch restarts at INITIAL_PC.
//     Also: redirect and bdone in the same cycle -> response dropped.

Source files
------------

// File: rtl/master_bus_pkg.sv
// master_bus_pkg: transaction type and size encodings of the master bus
package master_bus_pkg;
    typedef enum logic {READ, WRITE} ttype_e;
    typedef enum logic [1:0] {BYTE, HALF, WORD} tsize_e;
endpackage

// File: rtl/rv_pkg.sv
// rv_pkg: shared fetch-stage types for the rv32 core
package rv_pkg;
    typedef enum logic [2:0] {IDLE, REQ, WAIT, DRAIN, HALT} fetch_state_e;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
        logic        error;
    } fetch_entry_t;
endpackage

// File: rtl/master_bus_if.sv
// master_bus_if: single-master request/grant bus with start/done handshake
interface master_bus_if;
    import master_bus_pkg::*;
    logic        breq;
    logic        bgnt;
    logic        bstart;
    logic        bdone;
    logic        berror;
    ttype_e      ttype;
    tsize_e      tsize;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    modport master (output breq, bstart, ttype, tsize, addr, wdata, input bgnt, bdone, berror, rdata);
    modport slave (input breq, bstart, ttype, tsize, addr, wdata, output bgnt, bdone, berror, rdata);
endinterface

// File: rtl/rv_fetch_fifo.sv
// rv_fetch_fifo: sync FIFO with flush; head output holds its last value while empty
module rv_fetch_fifo
    import rv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter type T = fetch_entry_t,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  T              din,
    output T              head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    T mem [DEPTH];
    T hold_q;
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic do_pop, do_push;
    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction
    assign empty   = count == '0;
    assign full    = count == CW'(DEPTH);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = empty ? hold_q : mem[rd_ptr];
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            hold_q <= '0;
        end else begin
            if (!empty) hold_q <= mem[rd_ptr];
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= push ? nxt('0) : '0;
                count  <= push ? CW'(1) : '0;
                if (push) mem[0] <= din;
            end else begin
                if (do_push) begin
                    mem[wr_ptr] <= din;
                    wr_ptr      <= nxt(wr_ptr);
                end
                if (do_pop) rd_ptr <= nxt(rd_ptr);
                count <= count + CW'(do_push) - CW'(do_pop);
            end
        end
    end
endmodule

// File: rtl/rv_fetch_unit.sv
// rv_fetch_unit: fetch PC, single-outstanding ibus reads, redirect/flush and instruction buffer
module rv_fetch_unit
    import rv_pkg::*;
    import master_bus_pkg::*;
#(
    parameter logic [31:0] INITIAL_PC = 32'h0000_0000,
    parameter int          DEPTH      = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    master_bus_if.master ibus,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic         inst_valid,
    input  logic         inst_ready,
    output logic [31:0]  inst_data,
    output logic [31:0]  inst_pc,
    output logic         inst_error
);
    localparam int CW = $clog2(DEPTH + 1);
    fetch_state_e state, state_nxt;
    logic [31:0] fetch_pc, req_pc;
    logic halt_after, stray_ok, misaligned, in_flight, push, fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    fetch_entry_t push_entry, head;
    assign misaligned = redirect_pc[1:0] != 2'b00;
    assign in_flight  = ((state == WAIT || state == DRAIN) && !ibus.bdone) || (state == REQ && ibus.bgnt);
    assign push       = redirect_valid ? misaligned : (state == WAIT && ibus.bdone);
    always_comb begin
        push_entry.pc    = redirect_valid ? redirect_pc : req_pc;
        push_entry.data  = (redirect_valid || ibus.berror) ? 32'h0 : ibus.rdata;
        push_entry.error = redirect_valid || ibus.berror;
    end
    always_comb begin
        state_nxt = redirect_valid ? (in_flight ? DRAIN : misaligned ? HALT : IDLE) :
                    state == IDLE  ? (fifo_full ? IDLE : REQ) :
                    state == REQ   ? (ibus.bgnt ? WAIT : REQ) :
                    state == WAIT  ? (ibus.bdone ? (ibus.berror ? HALT : IDLE) : WAIT) :
                    state == DRAIN ? (ibus.bdone ? (halt_after ? HALT : IDLE) : DRAIN) : HALT;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            fetch_pc   <= INITIAL_PC;
            req_pc     <= INITIAL_PC;
            halt_after <= 1'b0;
            stray_ok   <= (stray_ok | ibus.breq) & ~ibus.bdone;
        end else begin
            state    <= state_nxt;
            stray_ok <= stray_ok & ~ibus.bdone;
            if (redirect_valid) begin
                fetch_pc   <= redirect_pc;
                halt_after <= misaligned;
            end else if (state == REQ && ibus.bgnt) begin
                fetch_pc <= fetch_pc + 32'd4;
                req_pc   <= fetch_pc;
            end
        end
    end
    assign ibus.breq   = state == REQ || state == WAIT || state == DRAIN;
    assign ibus.bstart = state == REQ;
    assign ibus.ttype  = READ;
    assign ibus.tsize  = WORD;
    assign ibus.addr   = fetch_pc;
    assign ibus.wdata  = 32'h0;
    rv_fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (inst_valid & inst_ready),
        .flush (redirect_valid),
        .din   (push_entry),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );
    assign inst_valid = ~fifo_empty;
    assign inst_pc    = head.pc;
    assign inst_data  = head.data;
    assign inst_error = head.error;
    // a bdone left over from a transaction abandoned by reset is tolerated once
    assert property (@(posedge clk) disable iff (!rst_n) ibus.bdone |-> (state == WAIT || state == DRAIN || stray_ok));
    assert property (@(posedge clk) disable iff (!rst_n) fifo_count <= CW'(DEPTH));
endmodule
